// File: rtl/q_mul_pipe.sv
// Four-stage pipelined quantised multiplier: C = clamp(round((a*b*G_AB + a*G_A + b*G_B + OFFSET) >>> SHIFT))
// with a single valid/ready stall domain and running MIN/MAX output statistics.
// Optional saturation counter output SAT_CNT is enabled by defining Q_MUL_PIPE_SAT_CNT_EN.
module q_mul_pipe #(
  parameter int DW  = 8,
  parameter int GW  = 32,
  parameter int SHW = 6
) (
  input  logic                 CLK,
  input  logic                 RESET_X,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DW-1:0]        A_IN,
  input  logic [DW-1:0]        B_IN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DW-1:0]        C_OUT,
  input  logic signed [GW-1:0] G_AB,
  input  logic signed [GW-1:0] G_A,
  input  logic signed [GW-1:0] G_B,
  input  logic signed [GW-1:0] OFFSET,
  input  logic [SHW-1:0]       SHIFT,
  input  logic                 STAT_CLR,
  output logic [DW-1:0]        MIN,
  output logic [DW-1:0]        MAX
`ifdef Q_MUL_PIPE_SAT_CNT_EN
  ,
  output logic [15:0]          SAT_CNT
`endif
);

  // Wide enough that the sum of the three products, offset and rounding term never overflows.
  localparam int ACCW = 2*DW + GW + 3;
  typedef logic signed [ACCW-1:0] acc_t;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, out_valid_q, out_valid_d;
  logic [DW-1:0]   a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
  logic [2*DW-1:0] p2_q, p2_d;
  acc_t            m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
  logic [DW-1:0]   c_q, c_d, min_q, min_d, max_q, max_d;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
  logic            sat_q, sat_d;
  logic [15:0]     sat_cnt_q, sat_cnt_d;
`endif

  logic adv, xfer, lo, hi;
  acc_t rnd, acc, r;

  // NOTE: every variable gets its hold value first, so stalled stages keep their contents and no latch is inferred.
  always_comb begin
    adv         = !out_valid_q || OUT_READY;
    xfer        = out_valid_q && OUT_READY;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    out_valid_d = out_valid_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    a2_d        = a2_q;
    b2_d        = b2_q;
    p2_d        = p2_q;
    m0_d        = m0_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    c_d         = c_q;
    min_d       = min_q;
    max_d       = max_q;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
    sat_d       = sat_q;
    sat_cnt_d   = sat_cnt_q;
`endif

    // Final stage: round-half-up, arithmetic shift, clamp to the unsigned code range.
    rnd = (SHIFT != '0) ? (acc_t'(1) <<< (SHIFT - SHW'(1))) : '0;
    acc = m0_q + m1_q + m2_q + acc_t'(OFFSET) + rnd;
    r   = acc >>> SHIFT;
    lo  = r[ACCW-1];
    hi  = !lo && (|r[ACCW-2:DW]);

    if (adv) begin
      v1_d        = IN_VALID;
      a1_d        = A_IN;
      b1_d        = B_IN;
      v2_d        = v1_q;
      a2_d        = a1_q;
      b2_d        = b1_q;
      p2_d        = {{DW{1'b0}}, a1_q} * {{DW{1'b0}}, b1_q};
      v3_d        = v2_q;
      m0_d        = acc_t'($signed({1'b0, p2_q})) * acc_t'(G_AB);
      m1_d        = acc_t'($signed({1'b0, a2_q})) * acc_t'(G_A);
      m2_d        = acc_t'($signed({1'b0, b2_q})) * acc_t'(G_B);
      out_valid_d = v3_q;
      if (v3_q) begin
        c_d = lo ? '0 : (hi ? '1 : r[DW-1:0]);
`ifdef Q_MUL_PIPE_SAT_CNT_EN
        sat_d = lo || hi;
`endif
      end
    end

    // A clear that coincides with a transfer restarts the statistics from that result.
    if (STAT_CLR) begin
      min_d = xfer ? c_q : '1;
      max_d = xfer ? c_q : '0;
    end else if (xfer) begin
      if (c_q < min_q) min_d = c_q;
      if (c_q > max_q) max_d = c_q;
    end

`ifdef Q_MUL_PIPE_SAT_CNT_EN
    if (STAT_CLR)
      sat_cnt_d = (xfer && sat_q) ? 16'd1 : 16'd0;
    else if (xfer && sat_q && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
`endif
  end

  // NOTE: non-blocking assignments make every stage sample pre-edge values, so the pipeline shifts as one.
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      a2_q        <= '0;
      b2_q        <= '0;
      p2_q        <= '0;
      m0_q        <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      c_q         <= '0;
      min_q       <= '1;
      max_q       <= '0;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
      sat_q       <= 1'b0;
      sat_cnt_q   <= '0;
`endif
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      a2_q        <= a2_d;
      b2_q        <= b2_d;
      p2_q        <= p2_d;
      m0_q        <= m0_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      c_q         <= c_d;
      min_q       <= min_d;
      max_q       <= max_d;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
      sat_q       <= sat_d;
      sat_cnt_q   <= sat_cnt_d;
`endif
    end
  end

  assign IN_READY  = adv;
  assign OUT_VALID = out_valid_q;
  assign C_OUT     = c_q;
  assign MIN       = min_q;
  assign MAX       = max_q;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
  assign SAT_CNT   = sat_cnt_q;
`endif

endmodule

// File: tb/tb_q_mul_pipe.sv
// Directed and constrained-random bench for q_mul_pipe (DW=8, GW=32, SHW=6).
module tb_q_mul_pipe;

  logic               CLK = 1'b0;
  logic               RESET_X;
  logic               IN_VALID, IN_READY, OUT_VALID, OUT_READY, STAT_CLR;
  logic [7:0]         A_IN, B_IN, C_OUT, MIN, MAX;
  logic signed [31:0] G_AB, G_A, G_B, OFFSET;
  logic [5:0]         SHIFT;
`ifdef Q_MUL_PIPE_SAT_CNT_EN
  logic [15:0]        SAT_CNT;
`endif

  int checks = 0;
  int errors = 0;

  q_mul_pipe #(.DW(8), .GW(32), .SHW(6)) dut (
    .CLK(CLK), .RESET_X(RESET_X),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A_IN(A_IN), .B_IN(B_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .C_OUT(C_OUT),
    .G_AB(G_AB), .G_A(G_A), .G_B(G_B), .OFFSET(OFFSET), .SHIFT(SHIFT),
    .STAT_CLR(STAT_CLR), .MIN(MIN), .MAX(MAX)
`ifdef Q_MUL_PIPE_SAT_CNT_EN
    , .SAT_CNT(SAT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_gains(input int gab, input int ga, input int gb, input int off, input int sh);
    G_AB = gab; G_A = ga; G_B = gb; OFFSET = off; SHIFT = 6'(sh);
  endtask

  // Sends one pair into an idle pipe (OUT_READY=1), checks the result, then lets it transfer.
  task automatic run_one(input string tag, input int a, input int b, input int exp, input bit clr);
    int n;
    IN_VALID = 1'b1; A_IN = 8'(a); B_IN = 8'(b);
    tick();
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, OUT_VALID, 1);
    check(tag, C_OUT, exp);
    STAT_CLR = clr;
    tick();
    STAT_CLR = 1'b0;
  endtask

  function automatic int ref_c(input int a, input int b, input longint gab, input longint ga,
                               input longint gb, input longint off, input int sh);
    longint acc;
    acc = longint'(a) * longint'(b) * gab + longint'(a) * ga + longint'(b) * gb + off;
    if (sh > 0) acc = acc + (longint'(1) <<< (sh - 1));
    acc = acc >>> sh;
    if (acc < 0)   return 0;
    if (acc > 255) return 255;
    return int'(acc);
  endfunction

  initial begin
    int sent, recv, stale, exp_v;
    bit acc_now;
    int gab, ga, gb, off;
    int exp_q[$];

    RESET_X = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; STAT_CLR = 1'b0;
    A_IN = '0; B_IN = '0;
    set_gains(1, 0, 0, 0, 8);
    repeat (3) tick();
    RESET_X = 1'b1;
    tick();
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_c_out", C_OUT, 0);
    check("rst_min", MIN, 255);
    check("rst_max", MAX, 0);
    check("rst_in_ready", IN_READY, 1);

    // Back-to-back pair: 255*255 -> 254, 16*16 -> 1 on cycles +4 and +5.
    IN_VALID = 1'b1; A_IN = 8'd255; B_IN = 8'd255;
    tick();
    A_IN = 8'd16; B_IN = 8'd16;
    tick();
    IN_VALID = 1'b0;
    tick();
    check("lat_not_yet", OUT_VALID, 0);
    tick();
    check("lat_valid0", OUT_VALID, 1);
    check("lat_c0", C_OUT, 254);
    tick();
    check("lat_valid1", OUT_VALID, 1);
    check("lat_c1", C_OUT, 1);
    tick();
    check("lat_drained", OUT_VALID, 0);
    check("lat_min", MIN, 1);
    check("lat_max", MAX, 254);

    // Clamps.
    set_gains(0, -1024, 0, 0, 0);
    run_one("clamp_lo", 10, 0, 0, 1'b0);
    set_gains(1024, 0, 0, 0, 0);
    run_one("clamp_hi", 255, 255, 255, 1'b0);
    check("clamp_min", MIN, 0);
    check("clamp_max", MAX, 255);
`ifdef Q_MUL_PIPE_SAT_CNT_EN
    check("sat_cnt", SAT_CNT, 2);
`endif

    // Statistics with identity mapping C = a.
    set_gains(0, 1, 0, 0, 0);
    STAT_CLR = 1'b1;
    tick();
    STAT_CLR = 1'b0;
    check("clr_min", MIN, 255);
    check("clr_max", MAX, 0);
    run_one("st40", 40, 0, 40, 1'b0);
    run_one("st7", 7, 0, 7, 1'b0);
    run_one("st200", 200, 0, 200, 1'b0);
    check("st_min", MIN, 7);
    check("st_max", MAX, 200);
    run_one("st90", 90, 3, 90, 1'b1);
    check("clrx_min", MIN, 90);
    check("clrx_max", MAX, 90);

    // Backpressure: stall from cycle 2 to 9, then drain all eight in order.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      OUT_READY = (cyc < 2) || (cyc >= 10);
      IN_VALID  = (sent < 8);
      A_IN = 8'(11 + sent); B_IN = 8'd0;
      #1;
      if (cyc >= 4 && cyc < 10) begin
        check("bp_in_ready", IN_READY, 0);
        check("bp_hold_valid", OUT_VALID, 1);
        check("bp_hold_c", C_OUT, 11);
      end
      if (OUT_VALID && OUT_READY) begin
        check("bp_order", C_OUT, 11 + recv);
        recv++;
      end
      acc_now = IN_VALID && IN_READY;
      tick();
      if (acc_now) sent++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    check("bp_sent", sent, 8);
    check("bp_recv", recv, 8);

    // Random traffic against the reference formula.
    gab = int'($urandom_range(0, 2097150)) - 1048575;
    ga  = int'($urandom_range(0, 2097150)) - 1048575;
    gb  = int'($urandom_range(0, 2097150)) - 1048575;
    off = int'($urandom_range(0, 2097150)) - 1048575;
    set_gains(gab, ga, gb, off, 12);
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      IN_VALID  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      A_IN = 8'($urandom_range(0, 255));
      B_IN = 8'($urandom_range(0, 255));
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("rand_spurious", OUT_VALID, 0);
        else begin
          exp_v = exp_q.pop_front();
          check("rand_c", C_OUT, exp_v);
        end
        recv++;
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(ref_c(int'(A_IN), int'(B_IN), gab, ga, gb, off, 12));
        sent++;
      end
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    check("rand_recv", recv, 1000);
    check("rand_left", exp_q.size(), 0);

    // Reset with three items in flight.
    set_gains(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; A_IN = 8'(50 + i); B_IN = 8'd0;
      tick();
    end
    IN_VALID = 1'b0;
    RESET_X = 1'b0;
    tick();
    RESET_X = 1'b1;
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_min", MIN, 255);
    check("mid_rst_max", MAX, 0);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (OUT_VALID) stale++;
      tick();
    end
    check("mid_rst_stale", stale, 0);
    run_one("post_rst", 33, 0, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
